// File: rtl/accel_spi_scheduler.sv
// Multi-byte accelerometer transaction sequencer in front of the single-byte spi_controller.
// Round-robin shares the controller between the manual-access path (0) and the X/Y/Z poller (1).
module accel_spi_scheduler #(
  parameter int CS_GAP_CYCLES  = 50,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        CLK100MHZ,
  input  logic        CPU_RESETN,
  input  logic [1:0]  req,
  input  logic [1:0]  write,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  input  logic [3:0]  len,
  output logic [1:0]  gnt,
  output logic [1:0]  ack,
  output logic [31:0] rdata,
  output logic        err,
  output logic        busy,
  output logic        spi_start,
  output logic [7:0]  spi_data_to_send,
  output logic        spi_hold_cs,
  input  logic [7:0]  spi_data_received,
  input  logic        spi_busy,
  input  logic        spi_done
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = (CS_GAP_CYCLES > 1) ? $clog2(CS_GAP_CYCLES) : 1;
  localparam logic [7:0] CMD_READ  = 8'h0B;
  localparam logic [7:0] CMD_WRITE = 8'h0A;

  typedef enum logic [2:0] {IDLE, START, WAIT, DONE, GAP} state_t;

  state_t          state_reg, state_next;
  logic            last_grant_reg;
  logic            op_write_reg;
  logic [7:0]      addr_reg;
  logic [7:0]      wdata_reg;
  logic [1:0]      len_reg;
  logic [2:0]      byte_idx_reg;
  logic [TW-1:0]   timer_reg;
  logic [GW-1:0]   gap_cnt_reg;
  logic            timeout_reg;
  logic [31:0]     rx_buf_reg;
  logic [31:0]     rdata_reg;
  logic [1:0]      gnt_reg;
  logic [7:0]      data_reg;
  logic            hold_reg;

  logic [7:0]      req_addr  [2];
  logic [7:0]      req_wdata [2];
  logic [1:0]      req_len   [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req_fields
      assign req_addr[gi]  = addr[8*gi +: 8];
      assign req_wdata[gi] = wdata[8*gi +: 8];
      assign req_len[gi]   = len[2*gi +: 2];
    end
  endgenerate

  logic        arb_ok;
  logic        arb_sel;
  logic [2:0]  last_idx;
  logic        last_byte;
  logic [2:0]  next_idx;
  logic [7:0]  next_byte;
  logic [1:0]  data_k;
  logic        timer_expired;
  logic        gap_expired;
  logic [31:0] rx_merged;

  assign gap_expired   = (gap_cnt_reg == '0);
  assign arb_ok        = (|req) && gap_expired && !spi_busy;
  // Both requesting: hand the controller to whoever did not have it last.
  assign arb_sel       = (req == 2'b11) ? ~last_grant_reg : req[1];
  assign last_idx      = op_write_reg ? 3'd2 : (3'd2 + {1'b0, len_reg});
  assign last_byte     = (byte_idx_reg == last_idx);
  assign next_idx      = byte_idx_reg + 3'd1;
  assign data_k        = byte_idx_reg[1:0] - 2'd2;
  assign timer_expired = (timer_reg == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    next_byte = 8'h00;
    if (next_idx == 3'd1)
      next_byte = addr_reg;
    else if (next_idx == 3'd2 && op_write_reg)
      next_byte = wdata_reg;
  end

  // Final read byte arrives on the same edge that enters DONE, so merge it in directly.
  always_comb begin
    rx_merged = rx_buf_reg;
    rx_merged[{len_reg, 3'b000} +: 8] = spi_data_received;
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    spi_start  = 1'b0;
    ack        = 2'b00;
    err        = 1'b0;
    busy       = 1'b1;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (arb_ok)
          state_next = START;
      end
      START: begin
        spi_start  = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (spi_done)
          state_next = last_byte ? DONE : START;
        else if (timer_expired)
          state_next = DONE;
      end
      DONE: begin
        ack        = gnt_reg;
        err        = timeout_reg;
        state_next = GAP;
      end
      GAP: begin
        if (gap_expired)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      last_grant_reg <= 1'b1;
      op_write_reg   <= 1'b0;
      addr_reg       <= 8'h00;
      wdata_reg      <= 8'h00;
      len_reg        <= 2'd0;
      byte_idx_reg   <= 3'd0;
      timer_reg      <= '0;
      gap_cnt_reg    <= '0;
      timeout_reg    <= 1'b0;
      rx_buf_reg     <= 32'h0;
      rdata_reg      <= 32'h0;
      gnt_reg        <= 2'b00;
      data_reg       <= 8'h00;
      hold_reg       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (arb_ok) begin
            last_grant_reg <= arb_sel;
            op_write_reg   <= write[arb_sel];
            addr_reg       <= req_addr[arb_sel];
            wdata_reg      <= req_wdata[arb_sel];
            len_reg        <= req_len[arb_sel];
            gnt_reg        <= arb_sel ? 2'b10 : 2'b01;
            byte_idx_reg   <= 3'd0;
            data_reg       <= write[arb_sel] ? CMD_WRITE : CMD_READ;
            hold_reg       <= 1'b1;
            timeout_reg    <= 1'b0;
            rx_buf_reg     <= 32'h0;
          end
        end
        START: begin
          timer_reg <= TW'(1);
        end
        WAIT: begin
          if (spi_done) begin
            if (!op_write_reg && byte_idx_reg >= 3'd2)
              rx_buf_reg[{data_k, 3'b000} +: 8] <= spi_data_received;
            if (last_byte) begin
              hold_reg <= 1'b0;
              if (!op_write_reg)
                rdata_reg <= rx_merged;
            end else begin
              byte_idx_reg <= next_idx;
              data_reg     <= next_byte;
              hold_reg     <= (next_idx != last_idx);
            end
          end else if (timer_expired) begin
            timeout_reg <= 1'b1;
            hold_reg    <= 1'b0;
          end else begin
            timer_reg <= timer_reg + TW'(1);
          end
        end
        DONE: begin
          gnt_reg     <= 2'b00;
          gap_cnt_reg <= GW'(CS_GAP_CYCLES - 1);
        end
        GAP: begin
          if (!gap_expired)
            gap_cnt_reg <= gap_cnt_reg - GW'(1);
        end
        default: ;
      endcase
    end
  end

  assign gnt              = gnt_reg;
  assign rdata            = rdata_reg;
  assign spi_data_to_send = data_reg;
  assign spi_hold_cs      = hold_reg;

endmodule

// File: tb/tb_accel_spi_scheduler.sv
// Randomized bench for accel_spi_scheduler: a byte-level SPI controller model answers each
// spi_start, and expected byte streams / rdata are built from the transaction rules.
module tb_accel_spi_scheduler;

  localparam int CS_GAP  = 50;
  localparam int TIMEOUT = 4096;

  logic        CLK100MHZ = 1'b0;
  logic        CPU_RESETN = 1'b0;
  logic [1:0]  req = '0, write = '0;
  logic [15:0] addr = '0, wdata = '0;
  logic [3:0]  len = '0;
  logic [1:0]  gnt, ack;
  logic [31:0] rdata;
  logic        err, busy, spi_start, spi_hold_cs;
  logic [7:0]  spi_data_to_send;
  logic [7:0]  spi_data_received;
  logic        spi_busy, spi_done;

  accel_spi_scheduler #(.CS_GAP_CYCLES(CS_GAP), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .CLK100MHZ(CLK100MHZ), .CPU_RESETN(CPU_RESETN),
    .req(req), .write(write), .addr(addr), .wdata(wdata), .len(len),
    .gnt(gnt), .ack(ack), .rdata(rdata), .err(err), .busy(busy),
    .spi_start(spi_start), .spi_data_to_send(spi_data_to_send), .spi_hold_cs(spi_hold_cs),
    .spi_data_received(spi_data_received), .spi_busy(spi_busy), .spi_done(spi_done)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  cap_data[$];
  logic        cap_hold[$];
  logic [7:0]  resp_q[$];
  int          gap_q[$];
  bit          model_on = 1'b1;
  int          cyc = 0;
  int          last_release = -1;
  logic [31:0] exp_rdata = 32'h0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [1:0] oh(input int r);
    return (r == 0) ? 2'b01 : 2'b10;
  endfunction

  // Byte-level controller model: random latency, returns queued response bytes.
  initial begin : spi_model
    int pending;
    logic [7:0] sent;
    logic stable;
    logic cur_hold;
    pending = 0; sent = 8'h00; stable = 1'b1; cur_hold = 1'b0;
    spi_done = 1'b0; spi_busy = 1'b0; spi_data_received = 8'h00;
    forever begin
      @(negedge CLK100MHZ);
      cyc++;
      spi_done = 1'b0;
      if (!CPU_RESETN) begin
        pending = 0;
        spi_busy = 1'b0;
        last_release = -1;
      end else if (pending > 0) begin
        if (spi_data_to_send !== sent) stable = 1'b0;
        pending--;
        if (pending == 0) begin
          spi_done = 1'b1;
          spi_busy = 1'b0;
          if (resp_q.size() > 0) spi_data_received = resp_q.pop_front();
          else spi_data_received = 8'h00;
          check_eq("data_stable", 32'(stable), 32'd1);
          if (!cur_hold) last_release = cyc;
        end
      end else if (spi_start && model_on) begin
        sent = spi_data_to_send;
        cur_hold = spi_hold_cs;
        stable = 1'b1;
        cap_data.push_back(sent);
        cap_hold.push_back(cur_hold);
        if (last_release >= 0) begin
          gap_q.push_back(cyc - last_release - 1);
          last_release = -1;
        end
        pending = $urandom_range(1, 5);
        spi_busy = 1'b1;
      end
    end
  end

  task automatic wait_idle();
    int c;
    c = 0;
    while (busy && c < 500) begin
      @(negedge CLK100MHZ);
      c++;
    end
  endtask

  task automatic wait_ack(output logic [1:0] a, output logic e, output int c);
    a = 2'b00; e = 1'b0; c = 0;
    while (a == 2'b00 && c < TIMEOUT + 2000) begin
      @(negedge CLK100MHZ);
      c++;
      if (ack != 2'b00) begin
        a = ack;
        e = err;
      end
    end
  endtask

  task automatic do_txn(input int r, input logic wr, input logic [7:0] a, input logic [7:0] wd,
                        input logic [1:0] ln, input logic [31:0] d, input bit drop);
    logic [7:0]  exp_b[$];
    logic [31:0] rd_exp;
    logic [1:0]  a_got;
    logic        e_got;
    int          c;
    wait_idle();
    cap_data.delete(); cap_hold.delete(); resp_q.delete(); exp_b.delete();
    rd_exp = exp_rdata;
    if (wr) begin
      exp_b.push_back(8'h0A); exp_b.push_back(a); exp_b.push_back(wd);
      repeat (3) resp_q.push_back(8'($urandom));
    end else begin
      exp_b.push_back(8'h0B); exp_b.push_back(a);
      repeat (2) resp_q.push_back(8'($urandom));
      rd_exp = 32'h0;
      for (int k = 0; k <= int'(ln); k++) begin
        exp_b.push_back(8'h00);
        resp_q.push_back(d[8*k +: 8]);
        rd_exp[8*k +: 8] = d[8*k +: 8];
      end
    end
    @(negedge CLK100MHZ);
    req[r] = 1'b1; write[r] = wr;
    addr[8*r +: 8] = a; wdata[8*r +: 8] = wd; len[2*r +: 2] = ln;
    c = 0;
    while (gnt == 2'b00 && c < 200) begin
      @(negedge CLK100MHZ);
      c++;
    end
    check_eq("gnt", 32'(gnt), 32'(oh(r)));
    check_eq("gnt_with_start", 32'(spi_start), 32'd1);
    // Fields changing after grant must not disturb the transaction.
    write[r] = ~wr; addr[8*r +: 8] = 8'($urandom); wdata[8*r +: 8] = 8'($urandom);
    len[2*r +: 2] = 2'($urandom);
    if (drop) req[r] = 1'b0;
    wait_ack(a_got, e_got, c);
    check_eq("ack", 32'(a_got), 32'(oh(r)));
    check_eq("err", 32'(e_got), 32'd0);
    check_eq("gnt_at_ack", 32'(gnt), 32'(oh(r)));
    check_eq("rdata", rdata, rd_exp);
    req[r] = 1'b0;
    @(negedge CLK100MHZ);
    check_eq("gnt_after_ack", 32'(gnt), 32'd0);
    check_eq("ack_one_cycle", 32'(ack), 32'd0);
    exp_rdata = rd_exp;
    check_eq("byte_count", 32'(cap_data.size()), 32'(exp_b.size()));
    if (cap_data.size() == exp_b.size()) begin
      for (int i = 0; i < exp_b.size(); i++) begin
        check_eq($sformatf("byte%0d", i), 32'(cap_data[i]), 32'(exp_b[i]));
        check_eq($sformatf("hold%0d", i), 32'(cap_hold[i]), (i == exp_b.size() - 1) ? 32'd0 : 32'd1);
      end
    end
    $display("txn req=%0d %s addr=%02h wdata=%02h len=%0d bytes=%0d rdata=%08h", r,
             wr ? "write" : "read ", a, wd, ln, cap_data.size(), rdata);
  endtask

  initial begin : main
    logic [1:0] a_got;
    logic       e_got;
    int         c;
    int         n;
    logic [1:0] ack_seen;

    #1;
    check_eq("rst_gnt", 32'(gnt), 32'd0);
    check_eq("rst_ack", 32'(ack), 32'd0);
    check_eq("rst_rdata", rdata, 32'd0);
    check_eq("rst_err_busy", 32'({err, busy}), 32'd0);
    check_eq("rst_spi", 32'({spi_start, spi_hold_cs, spi_data_to_send}), 32'd0);
    repeat (3) @(negedge CLK100MHZ);
    CPU_RESETN = 1'b1;
    @(negedge CLK100MHZ);

    // Contention from the first cycle: expect 0, 1, 0.
    write = 2'b11; addr = 16'h3322; wdata = 16'h5544; len = 4'h0;
    cap_data.delete(); cap_hold.delete(); gap_q.delete();
    req = 2'b11;
    for (int t = 0; t < 3; t++) begin
      wait_ack(a_got, e_got, c);
      check_eq($sformatf("rr_ack%0d", t), 32'(a_got), (t % 2 == 0) ? 32'd1 : 32'd2);
      $display("txn contention %0d ack=%b", t, a_got);
    end
    req = 2'b00;
    check_eq("rr_gap_count", 32'(gap_q.size()), 32'd2);
    for (int i = 0; i < gap_q.size(); i++)
      check_eq($sformatf("cs_gap%0d", i), 32'(gap_q[i] >= CS_GAP), 32'd1);
    if (cap_data.size() >= 6) begin
      check_eq("rr_addr0", 32'(cap_data[1]), 32'h22);
      check_eq("rr_wdata0", 32'(cap_data[2]), 32'h44);
      check_eq("rr_addr1", 32'(cap_data[4]), 32'h33);
      check_eq("rr_wdata1", 32'(cap_data[5]), 32'h55);
    end else begin
      check_eq("rr_bytes", 32'(cap_data.size()), 32'd9);
    end

    do_txn(0, 1'b0, 8'h00, 8'h00, 2'd0, 32'h000000AD, 1'b0);
    do_txn(1, 1'b0, 8'h0E, 8'h00, 2'd3, 32'h44332211, 1'b0);
    do_txn(0, 1'b1, 8'h2D, 8'h02, 2'd0, 32'h0, 1'b1);
    for (int i = 0; i < 10; i++)
      do_txn(int'($urandom_range(0, 1)), 1'($urandom), 8'($urandom), 8'($urandom),
             2'($urandom), $urandom, 1'($urandom));
    do_txn(1, 1'b0, 8'h32, 8'h00, 2'd1, 32'h0000C3A5, 1'b0);

    // Controller never answers: byte aborted TIMEOUT cycles after spi_start.
    wait_idle();
    model_on = 1'b0;
    @(negedge CLK100MHZ);
    req[0] = 1'b1; write[0] = 1'b0; addr[7:0] = 8'h42; len[1:0] = 2'd0;
    c = 0;
    while (!spi_start && c < 200) begin
      @(negedge CLK100MHZ);
      c++;
    end
    check_eq("to_start", 32'(spi_start), 32'd1);
    wait_ack(a_got, e_got, c);
    check_eq("to_cycles", 32'(c), 32'(TIMEOUT));
    check_eq("to_ack", 32'(a_got), 32'd1);
    check_eq("to_err", 32'(e_got), 32'd1);
    check_eq("to_rdata", rdata, exp_rdata);
    check_eq("to_hold", 32'(spi_hold_cs), 32'd0);
    req[0] = 1'b0;
    @(negedge CLK100MHZ);
    check_eq("to_gnt_drop", 32'(gnt), 32'd0);
    check_eq("to_err_pulse", 32'(err), 32'd0);
    check_eq("to_gap_busy", 32'(busy), 32'd1);
    $display("txn timeout ack=%b err=%b after %0d cycles", a_got, e_got, c);
    model_on = 1'b1;

    // Reset during the second byte of a burst read.
    wait_idle();
    resp_q.delete();
    repeat (6) resp_q.push_back(8'($urandom));
    @(negedge CLK100MHZ);
    req[1] = 1'b1; write[1] = 1'b0; addr[15:8] = 8'h10; len[3:2] = 2'd3;
    n = 0; c = 0;
    while (n < 2 && c < 300) begin
      @(negedge CLK100MHZ);
      c++;
      if (spi_start) n++;
    end
    check_eq("rst_second_byte", 32'(n), 32'd2);
    check_eq("rst_pre_gnt", 32'(gnt), 32'd2);
    #1 CPU_RESETN = 1'b0;
    #1;
    check_eq("arst_gnt", 32'(gnt), 32'd0);
    check_eq("arst_start", 32'(spi_start), 32'd0);
    check_eq("arst_hold", 32'(spi_hold_cs), 32'd0);
    check_eq("arst_rdata", rdata, 32'd0);
    check_eq("arst_busy", 32'(busy), 32'd0);
    exp_rdata = 32'h0;
    req[1] = 1'b0;
    ack_seen = 2'b00;
    repeat (3) begin
      @(negedge CLK100MHZ);
      ack_seen = ack_seen | ack;
    end
    check_eq("arst_no_ack", 32'(ack_seen), 32'd0);
    #2 CPU_RESETN = 1'b1;
    $display("txn reset during byte 2, no ack seen=%b", ack_seen);
    do_txn(0, 1'b0, 8'h0F, 8'h00, 2'd1, $urandom, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/accel_spi_scheduler.md
Name: accel_spi_scheduler

Overview:
- Sequences multi-byte accelerometer register transactions (command, address, data bytes) onto the single-byte spi_controller and shares it between two requesters.
- Requester 0 is the button/switch manual-access path; requester 1 is a periodic X/Y/Z data poller.
- Sits between the top-level control logic and spi_controller, replacing the hard-coded read/write FSM in the top level.

Parameters:
- CS_GAP_CYCLES, 50: minimum idle cycles (CS high) between consecutive transactions.
- TIMEOUT_CYCLES, 4096: maximum cycles from spi_start to spi_done before the byte is aborted.

Ports:
- CLK100MHZ  input  1  system clock, 100 MHz
- CPU_RESETN  input  1  reset, asynchronous, active-low
- req  input  2  per-requester request level; bit i = requester i
- write  input  2  per-requester op: 1 = write, 0 = read
- addr  input  16  register address; requester i uses addr[8i+7:8i]
- wdata  input  16  write byte; requester i uses wdata[8i+7:8i]
- len  input  4  read length minus 1 (0..3 = 1..4 bytes); requester i uses len[2i+1:2i]
- gnt  output  2  one-hot, high for the whole granted transaction
- ack  output  2  one-cycle completion pulse to the granted requester
- rdata  output  32  read result; byte k in rdata[8k+7:8k], unused bytes 0
- err  output  1  pulses with ack when the transaction timed out
- busy  output  1  high whenever the block is not in IDLE
- spi_start  output  1  one-cycle byte start to spi_controller
- spi_data_to_send  output  8  byte to transmit
- spi_hold_cs  output  1  keep CS low after the current byte
- spi_data_received  input  8  received byte, valid when spi_done=1
- spi_busy  input  1  controller busy
- spi_done  input  1  one-cycle end-of-byte pulse

Behaviour:
- Reset (async): state=IDLE; gnt, ack, err, spi_start, spi_hold_cs = 0; spi_data_to_send=0; rdata=0; gap counter already expired; last_grant=1.
- States:
  - IDLE: waits for any req with gap expired and spi_busy=0.
  - START: spi_start=1 for one cycle.
  - WAIT: waits for spi_done or timeout; more bytes -> START, last byte -> DONE.
  - DONE: ack pulse, one cycle.
  - GAP: counts CS_GAP_CYCLES, then IDLE.
- Arbitration, round-robin: if both req are high, grant the requester not in last_grant. A single requester always wins. Requester 0 wins first after reset.
- Grant: in the IDLE cycle where arbitration succeeds, latch that requester's write/addr/wdata/len. gnt is asserted the next cycle, together with the first spi_start. gnt stays high until the ack cycle inclusive.
- Byte sequence:
  - Read: 0x0B, addr, then len+1 bytes of 0x00.
  - Write: 0x0A, addr, wdata. len is ignored.
- spi_data_to_send: stable from the spi_start cycle through the spi_done cycle.
- spi_hold_cs: 1 for every byte except the last; 0 for the last.
- Read capture: on spi_done of data byte k (k = 0..len), an internal buffer byte k takes spi_data_received. rdata is updated from the buffer, upper bytes zeroed, in the DONE cycle only.
- Write: rdata is unchanged.
- Next byte: spi_start is issued the cycle after spi_done; no extra wait cycles.
- Timeout: the per-byte counter restarts at each spi_start. If it reaches TIMEOUT_CYCLES with no spi_done, go to DONE with err=1 and ack=1, rdata unchanged, spi_hold_cs=0, then GAP.
- Requester-side handshake:
  - req must stay high until ack. Dropping req mid-transaction does not abort it; ack still pulses.
  - Changing request fields after grant has no effect.
  - Re-asserted or still-high req is serviced again after GAP. last_grant is updated at grant.
- spi_done arriving in START or IDLE is ignored.
- Reset mid-transaction: all outputs return to reset values immediately; no ack is issued.

Test Plan:
- Read, requester 0, addr=0x00, len=0; model returns 0xAD on the data byte -> bytes 0B,00,00; hold_cs 1,1,0; ack[0] once; rdata=0x000000AD; err=0.
- Burst read, requester 1, addr=0x0E, len=3; model returns 11,22,33,44 -> 6 bytes, hold_cs low only on the 6th; rdata=0x44332211; ack[1] once.
- Write, requester 0, addr=0x2D, wdata=0x02 -> bytes 0A,2D,02; rdata unchanged; ack[0].
- Both req high from the same cycle after reset -> requester 0 served first, then requester 1. Between transactions CS is high and there are at least CS_GAP_CYCLES idle cycles before the second spi_start. Third contention cycle grants requester 0 again.
- Model never pulses spi_done -> exactly TIMEOUT_CYCLES after the first spi_start: ack and err pulse together, gnt drops, then GAP.
- CPU_RESETN low during the 2nd byte -> gnt, spi_start, spi_hold_cs, rdata = 0 asynchronously, no ack. After release, a new req is served normally.
